// File: rtl/stack_pkg.sv
// stack_pkg: shared types for the stack port arbiter
package stack_pkg;
    localparam int STACK_WIDTH = 16;
    typedef enum logic {CPU_PRI, DBG_LOCK} arb_state_t;
    typedef struct packed {
        logic change;
        logic dec;
        logic update;
    } stack_ctl_t;
endpackage

// File: rtl/stack_port_arbiter_if.sv
// stack_port_arbiter_if: requester, response and stack-side signals of the shared stack port
interface stack_port_arbiter_if
    import stack_pkg::*;
#(parameter int WIDTH = STACK_WIDTH);
    logic cpu_req, cpu_change, cpu_dec, cpu_update, cpu_gnt, cpu_rvalid;
    logic dbg_req, dbg_change, dbg_dec, dbg_update, dbg_lock, dbg_gnt, dbg_rvalid, dbg_starved;
    logic stk_change, stk_dec, stk_update;
    logic [WIDTH-1:0] cpu_d, dbg_d, rdata, stk_d, stk_q;
    modport slave (
        input  cpu_req, cpu_change, cpu_dec, cpu_update, cpu_d,
        input  dbg_req, dbg_change, dbg_dec, dbg_update, dbg_d, dbg_lock, stk_q,
        output cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, dbg_starved, rdata,
        output stk_d, stk_change, stk_dec, stk_update
    );
    modport master (
        output cpu_req, cpu_change, cpu_dec, cpu_update, cpu_d,
        output dbg_req, dbg_change, dbg_dec, dbg_update, dbg_d, dbg_lock, stk_q,
        input  cpu_gnt, cpu_rvalid, dbg_gnt, dbg_rvalid, dbg_starved, rdata,
        input  stk_d, stk_change, stk_dec, stk_update
    );
endinterface

// File: rtl/stack_port_arbiter.sv
// stack_port_arbiter: shares one stack port between the CPU (priority) and the debug monitor
module stack_port_arbiter
    import stack_pkg::*;
#(
    parameter int WIDTH    = STACK_WIDTH,
    parameter int MAX_WAIT = 8,
    parameter int LOCK_MAX = 64
) (
    input logic clk,
    input logic reset,
    stack_port_arbiter_if.slave bus
);
    localparam int WW = MAX_WAIT > 0 ? $clog2(MAX_WAIT + 1) : 1;
    localparam int LW = LOCK_MAX > 0 ? $clog2(LOCK_MAX + 1) : 1;
    typedef struct packed {
        stack_ctl_t       ctl;
        logic [WIDTH-1:0] d;
    } op_t;
    arb_state_t state, state_n;
    logic [WW-1:0] wait_cnt;
    logic [LW-1:0] lock_cnt;
    logic cpu_gnt, dbg_gnt, force_dbg, cpu_rvalid, dbg_rvalid;
    op_t cpu_op, dbg_op, op;
    // grants are held low while reset is asserted so outputs clear immediately
    always_comb begin
        force_dbg = 1'b0;
        cpu_gnt   = 1'b0;
        dbg_gnt   = 1'b0;
        state_n   = state;
        if (!reset) begin
            if (state == CPU_PRI) begin
                force_dbg = bus.dbg_req && wait_cnt == WW'(MAX_WAIT);
                cpu_gnt   = bus.cpu_req && !force_dbg;
                dbg_gnt   = bus.dbg_req && !cpu_gnt;
                state_n   = dbg_gnt && bus.dbg_lock ? DBG_LOCK : CPU_PRI;
            end else begin
                dbg_gnt = bus.dbg_req;
                state_n = !bus.dbg_lock || (LOCK_MAX > 0 && lock_cnt == LW'(LOCK_MAX)) ? CPU_PRI : DBG_LOCK;
            end
        end
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= CPU_PRI;
            wait_cnt   <= '0;
            lock_cnt   <= '0;
            cpu_rvalid <= 1'b0;
            dbg_rvalid <= 1'b0;
        end else begin
            state      <= state_n;
            cpu_rvalid <= cpu_gnt;
            dbg_rvalid <= dbg_gnt;
            wait_cnt   <= dbg_gnt || !bus.dbg_req ? '0 : wait_cnt == WW'(MAX_WAIT) ? wait_cnt : wait_cnt + 1'b1;
            lock_cnt   <= state == DBG_LOCK ? lock_cnt + 1'b1 : LW'(state_n == DBG_LOCK);
        end
    end
    assign cpu_op = {bus.cpu_change, bus.cpu_dec, bus.cpu_update, bus.cpu_d};
    assign dbg_op = {bus.dbg_change, bus.dbg_dec, bus.dbg_update, bus.dbg_d};
    assign op     = cpu_gnt ? cpu_op : dbg_gnt ? dbg_op : '0;
    assign bus.stk_change  = op.ctl.change;
    assign bus.stk_dec     = op.ctl.dec;
    assign bus.stk_update  = op.ctl.update;
    assign bus.stk_d       = op.d;
    assign bus.cpu_gnt     = cpu_gnt;
    assign bus.dbg_gnt     = dbg_gnt;
    assign bus.cpu_rvalid  = cpu_rvalid;
    assign bus.dbg_rvalid  = dbg_rvalid;
    assign bus.dbg_starved = force_dbg;
    assign bus.rdata       = bus.stk_q;
endmodule

// File: tb/tb_stack_port_arbiter.sv
// tb_stack_port_arbiter: two arbiter instances (8/64 and 0/4) checked against a cycle model
module tb_stack_port_arbiter;
    logic clk = 0, reset = 1;
    logic cpu_req = 0, cpu_change = 0, cpu_dec = 0, cpu_update = 0;
    logic dbg_req = 0, dbg_change = 0, dbg_dec = 0, dbg_update = 0, dbg_lock = 0;
    logic [15:0] cpu_d = 0, dbg_d = 0, sq = 0;
    int tests = 0, fails = 0;
    stack_port_arbiter_if #(.WIDTH(16)) ia(), ib();
    stack_port_arbiter #(.WIDTH(16), .MAX_WAIT(8), .LOCK_MAX(64)) dut_a (.clk(clk), .reset(reset), .bus(ia));
    stack_port_arbiter #(.WIDTH(16), .MAX_WAIT(0), .LOCK_MAX(4))  dut_b (.clk(clk), .reset(reset), .bus(ib));
    assign {ia.cpu_req, ia.cpu_change, ia.cpu_dec, ia.cpu_update, ia.cpu_d} = {cpu_req, cpu_change, cpu_dec, cpu_update, cpu_d};
    assign {ib.cpu_req, ib.cpu_change, ib.cpu_dec, ib.cpu_update, ib.cpu_d} = {cpu_req, cpu_change, cpu_dec, cpu_update, cpu_d};
    assign {ia.dbg_req, ia.dbg_change, ia.dbg_dec, ia.dbg_update, ia.dbg_d, ia.dbg_lock} = {dbg_req, dbg_change, dbg_dec, dbg_update, dbg_d, dbg_lock};
    assign {ib.dbg_req, ib.dbg_change, ib.dbg_dec, ib.dbg_update, ib.dbg_d, ib.dbg_lock} = {dbg_req, dbg_change, dbg_dec, dbg_update, dbg_d, dbg_lock};
    assign ia.stk_q = sq;
    assign ib.stk_q = sq;
    logic [1:0] a_cg, a_dg, a_cv, a_dv, a_ch, a_dc, a_up, a_st;
    logic [15:0] a_d[2], a_rd[2];
    assign a_cg = {ib.cpu_gnt, ia.cpu_gnt};
    assign a_dg = {ib.dbg_gnt, ia.dbg_gnt};
    assign a_cv = {ib.cpu_rvalid, ia.cpu_rvalid};
    assign a_dv = {ib.dbg_rvalid, ia.dbg_rvalid};
    assign a_ch = {ib.stk_change, ia.stk_change};
    assign a_dc = {ib.stk_dec, ia.stk_dec};
    assign a_up = {ib.stk_update, ia.stk_update};
    assign a_st = {ib.dbg_starved, ia.dbg_starved};
    assign a_d[0] = ia.stk_d;
    assign a_d[1] = ib.stk_d;
    assign a_rd[0] = ia.rdata;
    assign a_rd[1] = ib.rdata;

    always #5 clk = ~clk;

    task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    // reference model: per instance, lock status, burst length and consecutive debug losses
    int  mw[2] = '{8, 0};
    int  lm[2] = '{64, 4};
    bit  lk[2], pcg[2], pdg[2], ecg[2], edg[2], est[2];
    int  waits[2], blen[2];
    logic [15:0] ed;
    always begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            if (reset) begin
                lk[k] = 0; waits[k] = 0; blen[k] = 0;
                pcg[k] = 0; pdg[k] = 0; ecg[k] = 0; edg[k] = 0; est[k] = 0;
            end else begin
                est[k] = !lk[k] && dbg_req && waits[k] >= mw[k];
                ecg[k] = !lk[k] && cpu_req && !est[k];
                edg[k] = dbg_req && !ecg[k];
            end
            ed = ecg[k] ? cpu_d : edg[k] ? dbg_d : 16'h0;
            chk($sformatf("cpu_gnt[%0d]", k), a_cg[k], ecg[k]);
            chk($sformatf("dbg_gnt[%0d]", k), a_dg[k], edg[k]);
            chk($sformatf("cpu_rvalid[%0d]", k), a_cv[k], pcg[k]);
            chk($sformatf("dbg_rvalid[%0d]", k), a_dv[k], pdg[k]);
            chk($sformatf("dbg_starved[%0d]", k), a_st[k], est[k]);
            chk($sformatf("stk_change[%0d]", k), a_ch[k], ecg[k] ? cpu_change : edg[k] ? dbg_change : 1'b0);
            chk($sformatf("stk_dec[%0d]", k), a_dc[k], ecg[k] ? cpu_dec : edg[k] ? dbg_dec : 1'b0);
            chk($sformatf("stk_update[%0d]", k), a_up[k], ecg[k] ? cpu_update : edg[k] ? dbg_update : 1'b0);
            chk($sformatf("stk_d[%0d]", k), a_d[k], ed);
            chk($sformatf("rdata[%0d]", k), a_rd[k], sq);
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (!reset) begin
                if (lk[k]) begin
                    if (!dbg_lock || (lm[k] > 0 && blen[k] == lm[k])) lk[k] = 0;
                    else blen[k]++;
                end else if (edg[k] && dbg_lock) begin
                    lk[k] = 1;
                    blen[k] = 1;
                end
                waits[k] = (dbg_req && !edg[k]) ? (waits[k] < mw[k] ? waits[k] + 1 : mw[k]) : 0;
                pcg[k] = ecg[k];
                pdg[k] = edg[k];
            end
        end
    end

    initial begin
        cpu_req = 1;
        step;
        #1 chk("rst_cpu_gnt", a_cg[0], 0);
        chk("rst_cpu_rvalid", a_cv[0], 0);
        // push 1234 from the CPU alone
        step;
        reset = 0; cpu_change = 1; cpu_dec = 0; cpu_update = 0; cpu_d = 16'h1234; sq = 16'hBEEF;
        #1 chk("t1_cpu_gnt", a_cg[0], 1);
        chk("t1_stk_change", a_ch[0], 1);
        chk("t1_stk_dec", a_dc[0], 0);
        chk("t1_stk_d", a_d[0], 16'h1234);
        step;
        cpu_req = 0;
        #1 chk("t1_cpu_rvalid", a_cv[0], 1);
        chk("t1_rdata", a_rd[0], 16'hBEEF);
        chk("t5_stk_change", a_ch[0], 0);
        step;
        #1 chk("t5_cpu_rvalid", a_cv[0], 0);
        chk("t5_dbg_rvalid", a_dv[0], 0);
        chk("t5_stk_update", a_up[0], 0);
        // contention: eight CPU wins then a forced debug grant
        step;
        cpu_req = 1; dbg_req = 1; dbg_lock = 0; dbg_change = 1; dbg_dec = 1; dbg_d = 16'h0D0D;
        for (int i = 1; i <= 8; i++) begin
            #1 chk("t2_cpu_gnt", a_cg[0], 1);
            if (i == 1) chk("t2_b_dbg_tie", a_dg[1], 1);
            step;
        end
        #1 chk("t2_dbg_gnt", a_dg[0], 1);
        chk("t2_cpu_blocked", a_cg[0], 0);
        chk("t2_starved", a_st[0], 1);
        step;
        #1 chk("t2_cpu_again", a_cg[0], 1);
        // locked debug burst of five ops
        step;
        cpu_req = 0; dbg_lock = 1;
        #1 chk("t3_dbg_gnt1", a_dg[0], 1);
        step;
        cpu_req = 1;
        for (int i = 2; i <= 5; i++) begin
            if (i == 5) dbg_lock = 0;
            #1 chk("t3_dbg_gnt", a_dg[0], 1);
            chk("t3_cpu_gnt", a_cg[0], 0);
            step;
        end
        dbg_req = 0;
        #1 chk("t3_cpu_after", a_cg[0], 1);
        // lock stuck on: instance b must drop it after four locked cycles
        step;
        cpu_req = 0; dbg_req = 1; dbg_lock = 1;
        #1 chk("t4_b_dbg_gnt", a_dg[1], 1);
        step;
        cpu_req = 1; dbg_req = 0;
        for (int i = 0; i < 4; i++) begin
            #1 chk("t4_b_cpu_held", a_cg[1], 0);
            step;
        end
        #1 chk("t4_b_cpu_gnt", a_cg[1], 1);
        chk("t4_a_still_locked", a_cg[0], 0);
        // reset in the middle of instance a's burst
        step;
        #1 reset = 1;
        #1 chk("t6_cpu_gnt", a_cg[0], 0);
        chk("t6_stk_change", a_ch[0], 0);
        chk("t6_cpu_rvalid", a_cv[0], 0);
        step;
        reset = 0; dbg_req = 1; dbg_lock = 0;
        #1 chk("t6_cpu_first", a_cg[0], 1);
        for (int i = 2; i <= 9; i++) step;
        #1 chk("t6_wait_restart", a_dg[0], 1);
        // randomized traffic in phases of differing request/lock density
        for (int n = 0; n < 3000; n++) begin
            step;
            reset      = ($urandom_range(299) == 0);
            cpu_req    = $urandom_range(9) < ((n / 500) % 2 ? 9 : 5);
            dbg_req    = $urandom_range(9) < 8;
            dbg_lock   = $urandom_range(9) < (n >= 1500 ? 8 : 2);
            cpu_change = 1'($urandom_range(1));
            cpu_dec    = 1'($urandom_range(1));
            cpu_update = 1'($urandom_range(1));
            dbg_change = 1'($urandom_range(1));
            dbg_dec    = 1'($urandom_range(1));
            dbg_update = 1'($urandom_range(1));
            cpu_d      = 16'($urandom);
            dbg_d      = 16'($urandom);
            sq         = 16'($urandom);
        end
        step;
        reset = 0;
        repeat (2) step;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
